render_burst_writer: RTL and testbench

//  Frame-buffer write stage between the Mandelbrot rendering engine and DDR2 MCB port 0.

---
 rtl/render_burst_writer.sv | 124 ++++++++++++
 tb/tb_render_burst_writer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_burst_writer.sv
// render_burst_writer: double-buffered frame writer feeding DDR2 MCB port 0 in bursts (optional stall counter: RBW_STALL_CNT_EN)
module render_burst_writer #(
    parameter int          BURST_LEN   = 32,
    parameter int          FRAME_WORDS = 921600,
    parameter logic [29:0] BASE_ADDR0  = 30'h0000000,
    parameter logic [29:0] BASE_ADDR1  = 30'h0400000
) (
    input  logic        clk,
    input  logic        SYS_RESETn,
    input  logic        mem_calib_done,
    input  logic [31:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_last,
    output logic        p0_wr_en,
    output logic [31:0] p0_wr_data,
    output logic [3:0]  p0_wr_mask,
    input  logic        p0_wr_full,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        memory_frame,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] stall_cycles
);
    localparam int WW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FILL, CMD} state_t;

    state_t        state;
    logic [6:0]    cnt;
    logic [6:0]    cnt_inc;
    logic [WW-1:0] widx;
    logic [29:0]   ptr;
    logic          wr_frame;
    logic          frame_end;
    logic          limit_hit;
    logic          accept;
    logic          at_limit;
    logic          burst_full;

    assign pix_ready    = (state == FILL) && !p0_wr_full;
    assign accept       = pix_valid && pix_ready;
    assign p0_wr_en     = accept;
    assign p0_wr_data   = pix_data;
    assign p0_wr_mask   = 4'b0000;
    assign p0_cmd_instr = 3'b000;
    // The strobe follows cmd_full in the same cycle so a full command FIFO never sees a push
    assign p0_cmd_en    = (state == CMD) && !p0_cmd_full;
    assign cnt_inc      = cnt + 7'd1;
    assign at_limit     = widx == WW'(FRAME_WORDS - 1);
    assign burst_full   = cnt_inc == 7'(BURST_LEN);

    // Burst FSM: gathers words, issues one command per burst, flips frames at frame end
    always_ff @(posedge clk or negedge SYS_RESETn) begin
        if (!SYS_RESETn) begin
            state            <= IDLE;
            cnt              <= '0;
            widx             <= '0;
            ptr              <= BASE_ADDR0;
            wr_frame         <= 1'b0;
            memory_frame     <= 1'b1;
            frame_end        <= 1'b0;
            limit_hit        <= 1'b0;
            p0_cmd_bl        <= '0;
            p0_cmd_byte_addr <= '0;
            frame_done       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (mem_calib_done) state <= FILL;
                FILL: begin
                    if (accept) begin
                        cnt              <= cnt_inc;
                        widx             <= widx + WW'(1);
                        p0_cmd_bl        <= cnt[5:0];
                        p0_cmd_byte_addr <= ptr;
                        frame_end        <= pix_last || at_limit;
                        limit_hit        <= at_limit && !pix_last;
                        if (burst_full || pix_last || at_limit || !mem_calib_done) state <= CMD;
                    end else if (!mem_calib_done) begin
                        state <= (cnt == '0) ? IDLE : CMD;
                    end
                end
                CMD: begin
                    if (!p0_cmd_full) begin
                        cnt   <= '0;
                        state <= mem_calib_done ? FILL : IDLE;
                        if (frame_end) begin
                            wr_frame     <= ~wr_frame;
                            memory_frame <= wr_frame;
                            ptr          <= wr_frame ? BASE_ADDR0 : BASE_ADDR1;
                            widx         <= '0;
                            frame_done   <= 1'b1;
                            overflow     <= overflow | limit_hit;
                        end else begin
                            ptr <= ptr + {21'b0, cnt, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RBW_STALL_CNT_EN
    // Saturating count of back-pressured render cycles, restarted at each frame boundary
    always_ff @(posedge clk or negedge SYS_RESETn) begin
        if (!SYS_RESETn)
            stall_cycles <= '0;
        else if (frame_done)
            stall_cycles <= '0;
        else if (pix_valid && !pix_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_render_burst_writer.sv
// tb_render_burst_writer: directed self-checking bench for render_burst_writer (BURST_LEN=4, FRAME_WORDS=10)
module tb_render_burst_writer;
    logic        clk = 1'b0;
    logic        SYS_RESETn;
    logic        mem_calib_done;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic        p0_cmd_full;
    logic        memory_frame;
    logic        frame_done;
    logic        overflow;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    int cmd_total = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    logic [31:0] last_wr = '0;
    logic [35:0] cmdq[$];
    logic [15:0] stall_snap;
    logic [15:0] stall_exp;

    render_burst_writer #(
        .BURST_LEN(4),
        .FRAME_WORDS(10),
        .BASE_ADDR0(30'h0),
        .BASE_ADDR1(30'h100)
    ) dut (
        .clk(clk),
        .SYS_RESETn(SYS_RESETn),
        .mem_calib_done(mem_calib_done),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_last(pix_last),
        .p0_wr_en(p0_wr_en),
        .p0_wr_data(p0_wr_data),
        .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full),
        .p0_cmd_en(p0_cmd_en),
        .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr),
        .p0_cmd_full(p0_cmd_full),
        .memory_frame(memory_frame),
        .frame_done(frame_done),
        .overflow(overflow),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Port-side monitor sampled on the falling edge
    always @(negedge clk) begin
        if (p0_cmd_en) begin
            cmdq.push_back({p0_cmd_bl, p0_cmd_byte_addr});
            cmd_total++;
        end
        if (p0_wr_en) begin
            wr_cnt++;
            last_wr = p0_wr_data;
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        pix_data  = d;
        pix_valid = 1'b1;
        pix_last  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        chk("send_accept", {31'b0, ok}, 32'd1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic [5:0] bl, input logic [29:0] addr);
        logic [35:0] c;
        for (int t = 0; t < 20 && cmdq.size() == 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_present"}, {31'b0, cmdq.size() != 0}, 32'd1);
        if (cmdq.size() != 0) begin
            c = cmdq.pop_front();
            chk({tag, "_bl"}, {26'b0, c[35:30]}, {26'b0, bl});
            chk({tag, "_addr"}, {2'b0, c[29:0]}, {2'b0, addr});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        SYS_RESETn     = 1'b0;
        mem_calib_done = 1'b0;
        pix_data       = '0;
        pix_valid      = 1'b0;
        pix_last       = 1'b0;
        p0_wr_full     = 1'b0;
        p0_cmd_full    = 1'b0;
        cycles(3);
        chk("rst_ready", {31'b0, pix_ready}, 0);
        chk("rst_cmd_en", {31'b0, p0_cmd_en}, 0);
        chk("rst_bl", {26'b0, p0_cmd_bl}, 0);
        chk("rst_memframe", {31'b0, memory_frame}, 1);
        chk("rst_overflow", {31'b0, overflow}, 0);
        chk("rst_stall", {16'b0, stall_cycles}, 0);
        chk("rst_mask", {28'b0, p0_wr_mask}, 0);
        chk("rst_instr", {29'b0, p0_cmd_instr}, 0);
        SYS_RESETn = 1'b1;

        // Calibration low: nothing accepted, nothing issued
        pix_valid = 1'b1;
        pix_data  = 32'hDEAD;
        repeat (5) begin
            @(negedge clk);
            chk("nocal_ready", {31'b0, pix_ready}, 0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        chk("nocal_wr", wr_cnt, 0);
        chk("nocal_cmd", cmd_total, 0);
        mem_calib_done = 1'b1;

        // Ten-word frame with pix_last on the tenth word
        for (int i = 1; i <= 10; i++) send(32'h1000 + i, i == 10);
        check_cmd("f0_c0", 6'd3, 30'h000);
        check_cmd("f0_c1", 6'd3, 30'h010);
        check_cmd("f0_c2", 6'd1, 30'h020);
        cycles(3);
        chk("f0_fd", fd_cnt, 1);
        chk("f0_memframe", {31'b0, memory_frame}, 0);
        chk("f0_wr_cnt", wr_cnt, 10);
        chk("f0_last_data", last_wr, 32'h100A);

        // Short frame lands in frame 1 and flips back
        send(32'h2001, 1'b0);
        send(32'h2002, 1'b1);
        check_cmd("f1_c0", 6'd1, 30'h100);
        cycles(3);
        chk("f1_fd", fd_cnt, 2);
        chk("f1_memframe", {31'b0, memory_frame}, 1);

        // Write FIFO full for 5 cycles mid-burst
        send(32'h3001, 1'b0);
        send(32'h3002, 1'b0);
        stall_snap = stall_cycles;
        p0_wr_full = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = 32'h3003;
        repeat (5) begin
            @(negedge clk);
            chk("wfull_ready", {31'b0, pix_ready}, 0);
            chk("wfull_wr_en", {31'b0, p0_wr_en}, 0);
            @(posedge clk);
            #1;
        end
        pix_valid  = 1'b0;
        p0_wr_full = 1'b0;
`ifdef RBW_STALL_CNT_EN
        stall_exp = stall_snap + 16'd5;
`else
        stall_exp = 16'd0;
`endif
        chk("wfull_stall", {16'b0, stall_cycles}, {16'b0, stall_exp});
        send(32'h3003, 1'b0);
        send(32'h3004, 1'b0);
        check_cmd("wfull_c", 6'd3, 30'h000);

        // Command FIFO full for 3 cycles in CMD
        send(32'h3005, 1'b0);
        send(32'h3006, 1'b0);
        send(32'h3007, 1'b0);
        p0_cmd_full = 1'b1;
        send(32'h3008, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("cfull_cmd_en", {31'b0, p0_cmd_en}, 0);
            chk("cfull_bl", {26'b0, p0_cmd_bl}, 3);
            chk("cfull_addr", {2'b0, p0_cmd_byte_addr}, 32'h010);
            @(posedge clk);
            #1;
        end
        p0_cmd_full = 1'b0;
        @(negedge clk);
        chk("cfull_strobe", {31'b0, p0_cmd_en}, 1);
        check_cmd("cfull_c", 6'd3, 30'h010);
        cycles(3);
        chk("cfull_total", cmd_total, 6);

        // Frame limit reached without pix_last
        send(32'h3009, 1'b0);
        send(32'h300A, 1'b0);
        check_cmd("ovf_c0", 6'd1, 30'h020);
        send(32'h300B, 1'b0);
        send(32'h300C, 1'b0);
        chk("ovf_flag", {31'b0, overflow}, 1);
        chk("ovf_fd", fd_cnt, 3);
        chk("ovf_memframe", {31'b0, memory_frame}, 0);
        chk("ovf_stall_clr", {16'b0, stall_cycles}, 0);

        // Calibration drop mid-burst completes the partial command then idles
        mem_calib_done = 1'b0;
        check_cmd("ovf_c1", 6'd1, 30'h100);
        cycles(3);
        @(negedge clk);
        chk("cdrop_ready", {31'b0, pix_ready}, 0);
        chk("cdrop_total", cmd_total, 8);
        chk("cdrop_wr_cnt", wr_cnt, 24);
        chk("cdrop_ovf_sticky", {31'b0, overflow}, 1);
        @(posedge clk);
        #1;

        // Reset after two words of a burst
        mem_calib_done = 1'b1;
        send(32'h6001, 1'b0);
        send(32'h6002, 1'b0);
        SYS_RESETn = 1'b0;
        #1;
        chk("mrst_ready", {31'b0, pix_ready}, 0);
        chk("mrst_cmd_en", {31'b0, p0_cmd_en}, 0);
        chk("mrst_bl", {26'b0, p0_cmd_bl}, 0);
        chk("mrst_memframe", {31'b0, memory_frame}, 1);
        chk("mrst_overflow", {31'b0, overflow}, 0);
        chk("mrst_stall", {16'b0, stall_cycles}, 0);
        cycles(2);
        SYS_RESETn = 1'b1;
        chk("mrst_no_cmd", cmd_total, 8);
        for (int i = 1; i <= 4; i++) send(32'h6100 + i, 1'b0);
        check_cmd("mrst_c0", 6'd3, 30'h000);
        cycles(3);
        chk("mrst_total", cmd_total, 9);
        chk("mrst_fd", fd_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
